// File: rtl/uart_in_port_pkg.sv
// Shared definitions for the UART input port: FSM encoding, word geometry, timer sizing.
// UART_IN_PORT_PARITY_EN adds an even-parity state between the data bits and the stop bit.
package uart_in_port_pkg;

  localparam int BYTES_PER_WORD = 4;
  localparam int DATA_BITS      = 8;
  localparam int WORD_BITS      = BYTES_PER_WORD * DATA_BITS;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef UART_IN_PORT_PARITY_EN
    ST_PARITY = 3'd3,
`endif
    ST_STOP   = 3'd4
  } rx_state_t;

  // Bits needed to count 0..clks_per_bit-1.
  function automatic int timer_width(input int clks_per_bit);
    return (clks_per_bit <= 2) ? 1 : $clog2(clks_per_bit);
  endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// Byte receiver: rx synchronizer, start/data/stop FSM and bit timer.
// UART_IN_PORT_PARITY_EN inserts an even-parity check before the stop bit.
module uart_rx_byte
  import uart_in_port_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  output logic                 byte_valid,
  output logic [DATA_BITS-1:0] byte_data,
  output logic                 byte_err,
  output rx_state_t            state
);

  localparam int TW = timer_width(CLKS_PER_BIT);
  localparam logic [TW-1:0] T_HALF   = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] T_LAST   = TW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    LAST_BIT = 3'(DATA_BITS - 1);

  logic                 rx_meta_q, rx_meta_d;
  logic                 rx_s_q, rx_s_d;
  rx_state_t            state_q, state_d;
  logic [TW-1:0]        timer_q, timer_d;
  logic [2:0]           bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 rx_s;
  logic                 at_last;

  assign rx_s      = rx_s_q;
  assign at_last   = (timer_q == T_LAST);
  assign byte_data = shreg_q;
  assign state     = state_q;

  always_comb begin
    rx_meta_d  = rx;
    rx_s_d     = rx_meta_q;
    state_d    = state_q;
    timer_d    = timer_q;
    bit_idx_d  = bit_idx_q;
    shreg_d    = shreg_q;
    byte_valid = 1'b0;
    byte_err   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        timer_d   = '0;
        bit_idx_d = '0;
        if (!rx_s) state_d = ST_START;
      end
      ST_START: begin
        // Mid-start-bit sample: a high line means the low pulse was a glitch.
        if (timer_q == T_HALF) begin
          timer_d = '0;
          state_d = rx_s ? ST_IDLE : ST_DATA;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      ST_DATA: begin
        if (at_last) begin
          shreg_d = {rx_s, shreg_q[DATA_BITS-1:1]};
          timer_d = '0;
          if (bit_idx_q == LAST_BIT) begin
            bit_idx_d = '0;
`ifdef UART_IN_PORT_PARITY_EN
            state_d   = ST_PARITY;
`else
            state_d   = ST_STOP;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
`ifdef UART_IN_PORT_PARITY_EN
      ST_PARITY: begin
        if (at_last) begin
          timer_d = '0;
          if ((^shreg_q) == rx_s) begin
            state_d = ST_STOP;
          end else begin
            byte_err = 1'b1;
            state_d  = ST_IDLE;
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
`endif
      ST_STOP: begin
        if (at_last) begin
          timer_d    = '0;
          state_d    = ST_IDLE;
          byte_valid = rx_s;
          byte_err   = !rx_s;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      state_q   <= ST_IDLE;
      timer_q   <= '0;
      bit_idx_q <= '0;
      shreg_q   <= '0;
    end else begin
      rx_meta_q <= rx_meta_d;
      rx_s_q    <= rx_s_d;
      state_q   <= state_d;
      timer_q   <= timer_d;
      bit_idx_q <= bit_idx_d;
      shreg_q   <= shreg_d;
    end
  end

endmodule

// File: rtl/uart_in_port.sv
// UART input port: packs four received bytes (first byte in bits [7:0]) into a 32-bit word.
// UART_IN_PORT_PARITY_EN enables the even-parity check in the byte receiver.
module uart_in_port
  import uart_in_port_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  output logic [WORD_BITS-1:0] in_data,
  output logic                 in_strobe,
  output logic                 frame_err,
  output logic                 rx_busy
);

  localparam int CNT_W = $clog2(BYTES_PER_WORD);
  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(BYTES_PER_WORD - 1);

  logic                 byte_valid;
  logic [DATA_BITS-1:0] byte_data;
  logic                 byte_err;
  rx_state_t            rx_state;

  logic [CNT_W-1:0]     byte_cnt_q, byte_cnt_d;
  logic [WORD_BITS-1:0] word_q, word_d;
  logic [WORD_BITS-1:0] in_data_q, in_data_d;
  logic                 strobe_q, strobe_d;
  logic                 frame_err_q, frame_err_d;

  uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx_byte (
    .clk        (clk),
    .reset      (reset),
    .rx         (rx),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_err   (byte_err),
    .state      (rx_state)
  );

  always_comb begin
    byte_cnt_d  = byte_cnt_q;
    word_d      = word_q;
    in_data_d   = in_data_q;
    strobe_d    = 1'b0;
    frame_err_d = byte_err;
    // An error drops the partial word so the next good byte starts a fresh one.
    if (byte_err) begin
      byte_cnt_d = '0;
      word_d     = '0;
    end else if (byte_valid) begin
      word_d[byte_cnt_q*DATA_BITS +: DATA_BITS] = byte_data;
      byte_cnt_d = byte_cnt_q + 1'b1;
      if (byte_cnt_q == LAST_BYTE) begin
        in_data_d = word_d;
        strobe_d  = 1'b1;
        word_d    = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      byte_cnt_q  <= '0;
      word_q      <= '0;
      in_data_q   <= '0;
      strobe_q    <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      byte_cnt_q  <= byte_cnt_d;
      word_q      <= word_d;
      in_data_q   <= in_data_d;
      strobe_q    <= strobe_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign in_data   = in_data_q;
  assign in_strobe = strobe_q;
  assign frame_err = frame_err_q;
  assign rx_busy   = (rx_state != ST_IDLE);

endmodule

// File: tb/tb_uart_in_port.sv
// Self-checking bench for uart_in_port: vector table, corner sequences, random bytes vs a word model.
// Define UART_IN_PORT_PARITY_EN for the bench and RTL together to exercise the parity build.
module tb_uart_in_port;

  localparam int CPB = 16;
`ifdef UART_IN_PORT_PARITY_EN
  localparam bit PARITY_EN = 1'b1;
`else
  localparam bit PARITY_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        rx = 1'b1;
  logic [31:0] in_data;
  logic        in_strobe;
  logic        frame_err;
  logic        rx_busy;

  always #5 clk = ~clk;

  uart_in_port #(.CLKS_PER_BIT(CPB)) dut (
    .clk       (clk),
    .reset     (reset),
    .rx        (rx),
    .in_data   (in_data),
    .in_strobe (in_strobe),
    .frame_err (frame_err),
    .rx_busy   (rx_busy)
  );

  int n_checks = 0;
  int n_errors = 0;
  int strobe_cnt = 0;
  int err_cnt = 0;
  int exp_err_cnt = 0;
  int exp_words = 0;
  logic [31:0] prev_in_data = '0;
  logic [31:0] exp_q[$];
  logic [7:0]  part_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Reference: good bytes collect in order; four of them form a word, byte 0 in the low bits.
  task automatic model_byte(input logic [7:0] data, input bit ok);
    if (ok) begin
      part_q.push_back(data);
      if (part_q.size() == 4) begin
        exp_q.push_back({part_q[3], part_q[2], part_q[1], part_q[0]});
        exp_words++;
        part_q.delete();
      end
    end else begin
      part_q.delete();
      exp_err_cnt++;
    end
  endtask

  task automatic send_byte(input logic [7:0] data, input logic stop_bit, input bit par_flip,
                           input int gap);
    model_byte(data, stop_bit && !(PARITY_EN && par_flip));
    rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = data[i];
      tick(CPB);
    end
    if (PARITY_EN) begin
      rx = (^data) ^ par_flip;
      tick(CPB);
    end
    rx = stop_bit;
    tick(CPB);
    rx = 1'b1;
    tick(gap);
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      prev_in_data = in_data;
    end else begin
      if (in_strobe) begin
        strobe_cnt++;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL strobe_without_word: in_data 0x%08h, no word expected", in_data);
        end else begin
          check("strobe_word", in_data, exp_q.pop_front());
        end
        check("strobe_err_exclusive", {31'b0, frame_err}, 32'd0);
      end
      if (frame_err) err_cnt++;
      if (in_data !== prev_in_data) check("in_data_change_needs_strobe", {31'b0, in_strobe}, 32'd1);
      prev_in_data = in_data;
    end
  end

  typedef struct {
    logic [7:0]  data;
    logic        stop_bit;
    int          exp_strobes;
    int          exp_errs;
    logic [31:0] exp_in_data;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int s0, e0;
    logic [31:0] w1, w2;
    logic [7:0]  b2b[8];

    vecs[0] = '{8'h78, 1'b1, 0, 0, 32'h0000_0000};
    vecs[1] = '{8'h56, 1'b1, 0, 0, 32'h0000_0000};
    vecs[2] = '{8'h34, 1'b1, 0, 0, 32'h0000_0000};
    vecs[3] = '{8'h12, 1'b1, 1, 0, 32'h1234_5678};
    vecs[4] = '{8'hAA, 1'b1, 1, 0, 32'h1234_5678};
    vecs[5] = '{8'h55, 1'b0, 1, 1, 32'h1234_5678};
    vecs[6] = '{8'h01, 1'b1, 1, 1, 32'h1234_5678};
    vecs[7] = '{8'h02, 1'b1, 1, 1, 32'h1234_5678};
    vecs[8] = '{8'h03, 1'b1, 1, 1, 32'h1234_5678};
    vecs[9] = '{8'h04, 1'b1, 2, 1, 32'h0403_0201};

    reset = 1'b0;
    rx = 1'b1;
    tick(5);
    check("reset_in_data", in_data, 32'd0);
    check("reset_in_strobe", {31'b0, in_strobe}, 32'd0);
    check("reset_frame_err", {31'b0, frame_err}, 32'd0);
    check("reset_rx_busy", {31'b0, rx_busy}, 32'd0);
    reset = 1'b1;
    tick(5);

    s0 = strobe_cnt;
    e0 = err_cnt;
    for (int i = 0; i < 10; i++) begin
      send_byte(vecs[i].data, vecs[i].stop_bit, 1'b0, 24);
      check($sformatf("vec%0d_strobes", i), strobe_cnt - s0, vecs[i].exp_strobes);
      check($sformatf("vec%0d_errs", i), err_cnt - e0, vecs[i].exp_errs);
      check($sformatf("vec%0d_in_data", i), in_data, vecs[i].exp_in_data);
    end

    // Short low pulse from idle is rejected at the start-bit sample.
    s0 = strobe_cnt;
    e0 = err_cnt;
    rx = 1'b0;
    tick(4);
    rx = 1'b1;
    tick(1);
    check("glitch_busy_in_start", {31'b0, rx_busy}, 32'd1);
    tick(30);
    check("glitch_back_idle", {31'b0, rx_busy}, 32'd0);
    check("glitch_no_err", err_cnt - e0, 32'd0);
    check("glitch_no_strobe", strobe_cnt - s0, 32'd0);
    check("glitch_in_data", in_data, 32'h0403_0201);

    // Reset during bit 3 of byte 2 abandons the frame and the partial word.
    send_byte(8'h11, 1'b1, 1'b0, 24);
    send_byte(8'h22, 1'b1, 1'b0, 24);
    s0 = strobe_cnt;
    e0 = err_cnt;
    rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 3; i++) begin
      rx = 8'h33 >> i;
      tick(CPB);
    end
    rx = 1'b0;
    tick(CPB / 2);
    reset = 1'b0;
    rx = 1'b1;
    part_q.delete();
    tick(3);
    check("midreset_busy", {31'b0, rx_busy}, 32'd0);
    check("midreset_in_data", in_data, 32'd0);
    reset = 1'b1;
    tick(20);
    send_byte(8'hEF, 1'b1, 1'b0, 24);
    send_byte(8'hBE, 1'b1, 1'b0, 24);
    send_byte(8'hAD, 1'b1, 1'b0, 24);
    send_byte(8'hDE, 1'b1, 1'b0, 24);
    check("midreset_word", in_data, 32'hDEAD_BEEF);
    check("midreset_one_strobe", strobe_cnt - s0, 32'd1);
    check("midreset_no_err", err_cnt - e0, 32'd0);

    // Eight bytes with no idle gap between frames.
    s0 = strobe_cnt;
    for (int i = 0; i < 8; i++) b2b[i] = 8'($urandom_range(0, 255));
    w1 = {b2b[3], b2b[2], b2b[1], b2b[0]};
    w2 = {b2b[7], b2b[6], b2b[5], b2b[4]};
    for (int i = 0; i < 8; i++) begin
      send_byte(b2b[i], 1'b1, 1'b0, (i == 7) ? 24 : 0);
      if (i >= 3 && i < 7) check($sformatf("b2b_hold_%0d", i), in_data, w1);
    end
    check("b2b_word2", in_data, w2);
    check("b2b_two_strobes", strobe_cnt - s0, 32'd2);

`ifdef UART_IN_PORT_PARITY_EN
    e0 = err_cnt;
    send_byte(8'h03, 1'b1, 1'b1, 24);
    check("parity_err", err_cnt - e0, 32'd1);
    send_byte(8'h01, 1'b1, 1'b0, 24);
    send_byte(8'h00, 1'b1, 1'b0, 24);
    send_byte(8'h00, 1'b1, 1'b0, 24);
    send_byte(8'h00, 1'b1, 1'b0, 24);
    check("parity_word", in_data, 32'h0000_0001);
`endif

    // Random bytes, occasional bad stop bits; idle after an error lets the receiver settle.
    for (int i = 0; i < 24; i++) begin
      logic [7:0] d;
      logic       stop_ok;
      d = 8'($urandom_range(0, 255));
      stop_ok = ($urandom_range(0, 7) != 0);
      send_byte(d, stop_ok, 1'b0, stop_ok ? $urandom_range(0, 5) : 24);
    end
    tick(40);

    check("final_exp_q_empty", exp_q.size(), 32'd0);
    check("final_err_count", err_cnt, exp_err_cnt);
    check("final_strobe_count", strobe_cnt, exp_words);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_in_port.md
UART_IN_PORT -- requirements
Module: uart_in_port

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 16: clk cycles per serial bit; legal range 4..65535.
REQ-002 SHALL have port clk, input, 1: single clock, rising-edge only.
REQ-003 SHALL have port reset, input, 1: reset, synchronous, active-low (0 = reset).
REQ-004 SHALL have port rx, input, 1: asynchronous serial line, idle high, 8 data bits LSB first, one stop bit.
REQ-005 SHALL have port in_data, output, 32: last complete word; drives the processor InPort.
REQ-006 SHALL have port in_strobe, output, 1: one-cycle pulse when in_data updates; drives the processor InStrobe.
REQ-007 SHALL have port frame_err, output, 1: one-cycle pulse on a framing or parity error.
REQ-008 SHALL have port rx_busy, output, 1: high whenever the FSM is not IDLE.

Function
REQ-009 SHALL pass rx through a two-flop synchronizer; every internal reference to rx uses the synchronized value rx_s.
REQ-010 SHALL implement FSM states IDLE, START, DATA, PARITY (macro only), STOP.
REQ-011 IDLE->START SHALL occur on the first cycle with rx_s=0; the bit timer then loads 0.
REQ-012 In START, the FSM SHALL sample at timer = CLKS_PER_BIT/2-1 (floor): rx_s=1 -> glitch, return to IDLE with no error; rx_s=0 -> DATA with the timer cleared.
REQ-013 In DATA, the FSM SHALL sample one bit each time the timer reaches CLKS_PER_BIT-1, shift it in LSB first, and clear the timer; after bit 7 it goes to STOP, or to PARITY when the macro is set.
REQ-014 In STOP, the FSM SHALL sample at timer = CLKS_PER_BIT-1; rx_s=1 accepts the byte; rx_s=0 pulses frame_err, discards the byte, and clears the byte counter; both cases return to IDLE.
REQ-015 Accepted byte k (k = 0..3) SHALL be written to word bits [8k+7:8k], and the 2-bit byte counter SHALL increment and wrap from 3 to 0.
REQ-016 On acceptance of byte 3, in_data SHALL load the assembled word and in_strobe SHALL be high for exactly the next cycle.
REQ-017 in_data SHALL hold its value between strobes; partial words SHALL never appear on in_data.
REQ-018 A framing error SHALL discard all partial word bytes, so the next accepted byte becomes byte 0.
REQ-019 rx activity during STOP before the sample point SHALL be ignored; a new start bit is detectable only from IDLE.
REQ-020 in_strobe and frame_err SHALL never be high in the same cycle.

Reset
REQ-021 While reset=0 at a clk edge: FSM->IDLE; timer, bit index, and byte counter->0; partial word->0; in_data=0; in_strobe=0; frame_err=0; rx_busy=0; synchronizer flops->1.
REQ-022 Reset mid-frame SHALL abandon the frame silently, with no strobe and no error.

Configuration
REQ-023 Macro UART_IN_PORT_PARITY_EN defined: a PARITY state follows DATA, samples one even-parity bit at timer = CLKS_PER_BIT-1, and on mismatch pulses frame_err and discards the byte and partial word as in REQ-018.
REQ-024 Macro undefined: no PARITY state and no parity logic; the frame is 10 bits.

Structure
REQ-025 Package uart_in_port_pkg SHALL hold the FSM state encoding, BYTES_PER_WORD=4, DATA_BITS=8, and the timer width function.
REQ-026 Sub-module uart_rx_byte SHALL hold the synchronizer, FSM, and timer, and output byte_valid/byte_data/byte_err; the top level holds word assembly and the strobe.

Verification (CLKS_PER_BIT=16, no macro unless stated)
REQ-027 Send bytes 0x78,0x56,0x34,0x12 -> in_data=0x12345678, one in_strobe pulse after the 4th stop sample, frame_err never high.
REQ-028 Pulse rx low for 4 cycles from idle -> START rejects it, returns to IDLE, no frame_err, in_data unchanged.
REQ-029 Send 0xAA, then 0x55 with stop=0, then 0x01,0x02,0x03,0x04 -> one frame_err pulse, then in_data=0x04030201 with a single strobe.
REQ-030 Assert reset during bit 3 of byte 2 of a word, release, send 4 fresh bytes 0xEF,0xBE,0xAD,0xDE -> in_data=0xDEADBEEF, exactly one strobe.
REQ-031 With UART_IN_PORT_PARITY_EN: byte 0x03 with parity bit 1 -> frame_err; bytes 0x01,0x00,0x00,0x00 with correct parity -> in_data=0x00000001.
REQ-032 Send 8 back-to-back bytes with no idle gap -> two strobes; in_data holds the first word until the second strobe.
